// File: rtl/motor_ctrl_pkg.sv
// rtl/motor_ctrl_pkg.sv - register map, reset constants and shared types for the motor register file
package motor_ctrl_pkg;

  // Motor page register offsets
  localparam logic [4:0] REG_KP           = 5'h00;
  localparam logic [4:0] REG_KI           = 5'h01;
  localparam logic [4:0] REG_KD           = 5'h02;
  localparam logic [4:0] REG_PWM_LIMIT    = 5'h03;
  localparam logic [4:0] REG_INT_LIMIT    = 5'h04;
  localparam logic [4:0] REG_DEADBAND     = 5'h05;
  localparam logic [4:0] REG_CONTROL_MODE = 5'h06;
  localparam logic [4:0] REG_SP           = 5'h07;
  localparam logic [4:0] REG_ENC0_POS     = 5'h08;
  localparam logic [4:0] REG_ENC1_POS     = 5'h09;
  localparam logic [4:0] REG_ENC0_VEL     = 5'h0A;
  localparam logic [4:0] REG_ENC1_VEL     = 5'h0B;
  localparam logic [4:0] REG_CUR1         = 5'h0C;
  localparam logic [4:0] REG_CUR2         = 5'h0D;
  localparam logic [4:0] REG_CUR3         = 5'h0E;
  localparam logic [4:0] REG_ERROR_CODE   = 5'h0F;
  localparam logic [4:0] REG_TRIGGER      = 5'h10;

  // Global page register offsets
  localparam logic [4:0] GREG_STATUS_FREQ = 5'h00;
  localparam logic [4:0] GREG_PEND_CTRL   = 5'h01;
  localparam logic [4:0] GREG_PEND_SP     = 5'h02;
  localparam logic [4:0] GREG_NUM_MOTORS  = 5'h03;
  localparam logic [4:0] GREG_BROADCAST   = 5'h04;

  // Configuration reset values
  localparam int KP_RESET        = 1;
  localparam int PWM_LIMIT_RESET = 127;
  localparam int INT_LIMIT_RESET = 50;

  // Returned for unmapped addresses
  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  typedef enum logic {
    UPD_CTRL = 1'b0,
    UPD_SP   = 1'b1
  } upd_kind_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_REQ  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/motor_update_arbiter.sv
// rtl/motor_update_arbiter.sv - pending-update masks with round-robin req/ack handoff to coms
module motor_update_arbiter
  import motor_ctrl_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int MI_W = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUMBER_OF_MOTORS-1:0] set_ctrl,
  input  logic [NUMBER_OF_MOTORS-1:0] set_sp,
  input  logic                        upd_ack,
  output logic [NUMBER_OF_MOTORS-1:0] pend_ctrl,
  output logic [NUMBER_OF_MOTORS-1:0] pend_sp,
  output logic                        upd_req,
  output logic [MI_W-1:0]             upd_motor,
  output upd_kind_e                   upd_kind
);

  localparam int N = NUMBER_OF_MOTORS;

  arb_state_e            state, state_nxt;
  logic [MI_W-1:0]       rr_ptr;
  logic                  found;
  logic [MI_W-1:0]       win_motor;
  upd_kind_e             win_kind;
  logic [N-1:0]          clr_ctrl, clr_sp;
  logic [N-1:0]          served_onehot;

  assign upd_req       = (state == ARB_REQ);
  assign served_onehot = N'(1) << upd_motor;

  // Round-robin scan: first motor at or after rr_ptr with any flag; ctrl beats sp
  always_comb begin
    found     = 1'b0;
    win_motor = '0;
    win_kind  = UPD_CTRL;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && (pend_ctrl[idx] || pend_sp[idx])) begin
        found     = 1'b1;
        win_motor = MI_W'(idx);
        win_kind  = pend_ctrl[idx] ? UPD_CTRL : UPD_SP;
      end
    end
  end

  // Next state and clear pulses for the flag served by an ack
  always_comb begin
    state_nxt = state;
    clr_ctrl  = '0;
    clr_sp    = '0;
    case (state)
      ARB_IDLE: if (found) state_nxt = ARB_REQ;
      ARB_REQ: begin
        if (upd_ack) begin
          state_nxt = ARB_IDLE;
          if (upd_kind == UPD_CTRL) clr_ctrl = served_onehot;
          else                      clr_sp   = served_onehot;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // State, masks (set wins over a same-edge clear), latched request and pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ARB_IDLE;
      pend_ctrl <= '0;
      pend_sp   <= '0;
      rr_ptr    <= '0;
      upd_motor <= '0;
      upd_kind  <= UPD_CTRL;
    end else begin
      state     <= state_nxt;
      pend_ctrl <= (pend_ctrl & ~clr_ctrl) | set_ctrl;
      pend_sp   <= (pend_sp & ~clr_sp) | set_sp;
      if (state == ARB_IDLE && found) begin
        upd_motor <= win_motor;
        upd_kind  <= win_kind;
      end
      if (state == ARB_REQ && upd_ack) begin
        rr_ptr <= (upd_motor == MI_W'(N - 1)) ? '0 : upd_motor + 1'b1;
      end
    end
  end

endmodule

// File: rtl/motor_ctrl_regfile.sv
// rtl/motor_ctrl_regfile.sv - Avalon-MM register file for N-motor configuration and status
module motor_ctrl_regfile
  import motor_ctrl_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS  = 6,
  parameter int DATA_WIDTH        = 32,
  parameter int MI_W              = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1,
  parameter int ADDR_W            = MI_W + 6,
  parameter int STATUS_FREQ_RESET = 100
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [ADDR_W-1:0]                  address,
  input  logic                               write,
  input  logic                               read,
  input  logic [DATA_WIDTH-1:0]              writedata,
  output logic [DATA_WIDTH-1:0]              readdata,
  output logic                               waitrequest,
  output logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] cfg_kp,
  output logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] cfg_ki,
  output logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] cfg_kd,
  output logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] cfg_pwm_limit,
  output logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] cfg_int_limit,
  output logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] cfg_deadband,
  output logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] cfg_sp,
  output logic [NUMBER_OF_MOTORS*8-1:0]          cfg_control_mode,
  output logic [31:0]                            status_update_frequency_Hz,
  input  logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] st_enc0_pos,
  input  logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] st_enc1_pos,
  input  logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] st_enc0_vel,
  input  logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] st_enc1_vel,
  input  logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] st_cur1,
  input  logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] st_cur2,
  input  logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] st_cur3,
  input  logic [NUMBER_OF_MOTORS*8-1:0]          st_error_code,
  input  logic                               status_strobe,
  output logic                               upd_req,
  output logic [MI_W-1:0]                    upd_motor,
  output logic                               upd_kind,
  input  logic                               upd_ack
);

  localparam int N  = NUMBER_OF_MOTORS;
  localparam int DW = DATA_WIDTH;

  logic            page;
  logic [MI_W-1:0] motor_idx;
  logic [4:0]      reg_sel;
  logic            motor_ok;
  logic [DW-1:0]   motor_rd [N];
  logic [DW-1:0]   rd_value;
  logic            rd_phase;
  logic [31:0]     status_freq;
  logic [N-1:0]    set_ctrl, set_sp, pend_ctrl, pend_sp;
  upd_kind_e       arb_kind;

  assign page        = address[ADDR_W-1];
  assign motor_idx   = address[5 +: MI_W];
  assign reg_sel     = address[4:0];
  assign motor_ok    = ({1'b0, motor_idx} < (MI_W + 1)'(N));
  assign waitrequest = ~rd_phase;
  assign upd_kind    = arb_kind;
  assign status_update_frequency_Hz = status_freq;

  for (genvar m = 0; m < N; m++) begin : g_motor
    logic [DW-1:0] kp, ki, kd, pwm_limit, int_limit, deadband, sp;
    logic [7:0]    control_mode;
    logic [DW-1:0] sh_enc0_pos, sh_enc1_pos, sh_enc0_vel, sh_enc1_vel;
    logic [DW-1:0] sh_cur1, sh_cur2, sh_cur3;
    logic [7:0]    sh_error_code;
    logic          wr_sel;
    logic [DW-1:0] rd_word;

    assign wr_sel = write && !page && (motor_idx == MI_W'(m));

    // Per-motor configuration, written straight from the decoded address
    always_ff @(posedge clock) begin
      if (reset) begin
        kp           <= DW'(KP_RESET);
        ki           <= '0;
        kd           <= '0;
        pwm_limit    <= DW'(PWM_LIMIT_RESET);
        int_limit    <= DW'(INT_LIMIT_RESET);
        deadband     <= '0;
        sp           <= '0;
        control_mode <= '0;
      end else if (wr_sel) begin
        case (reg_sel)
          REG_KP:           kp           <= writedata;
          REG_KI:           ki           <= writedata;
          REG_KD:           kd           <= writedata;
          REG_PWM_LIMIT:    pwm_limit    <= writedata;
          REG_INT_LIMIT:    int_limit    <= writedata;
          REG_DEADBAND:     deadband     <= writedata;
          REG_CONTROL_MODE: control_mode <= writedata[7:0];
          REG_SP:           sp           <= writedata;
          default: ;
        endcase
      end
    end

    // Status shadows all load on the strobe edge so a read sees one coherent snapshot
    always_ff @(posedge clock) begin
      if (reset) begin
        sh_enc0_pos   <= '0;
        sh_enc1_pos   <= '0;
        sh_enc0_vel   <= '0;
        sh_enc1_vel   <= '0;
        sh_cur1       <= '0;
        sh_cur2       <= '0;
        sh_cur3       <= '0;
        sh_error_code <= '0;
      end else if (status_strobe) begin
        sh_enc0_pos   <= st_enc0_pos[m*DW +: DW];
        sh_enc1_pos   <= st_enc1_pos[m*DW +: DW];
        sh_enc0_vel   <= st_enc0_vel[m*DW +: DW];
        sh_enc1_vel   <= st_enc1_vel[m*DW +: DW];
        sh_cur1       <= st_cur1[m*DW +: DW];
        sh_cur2       <= st_cur2[m*DW +: DW];
        sh_cur3       <= st_cur3[m*DW +: DW];
        sh_error_code <= st_error_code[m*8 +: 8];
      end
    end

    // Motor page read word for this channel
    always_comb begin
      rd_word = DW'(DEADBEEF);
      case (reg_sel)
        REG_KP:           rd_word = kp;
        REG_KI:           rd_word = ki;
        REG_KD:           rd_word = kd;
        REG_PWM_LIMIT:    rd_word = pwm_limit;
        REG_INT_LIMIT:    rd_word = int_limit;
        REG_DEADBAND:     rd_word = deadband;
        REG_CONTROL_MODE: rd_word = DW'(control_mode);
        REG_SP:           rd_word = sp;
        REG_ENC0_POS:     rd_word = sh_enc0_pos;
        REG_ENC1_POS:     rd_word = sh_enc1_pos;
        REG_ENC0_VEL:     rd_word = sh_enc0_vel;
        REG_ENC1_VEL:     rd_word = sh_enc1_vel;
        REG_CUR1:         rd_word = sh_cur1;
        REG_CUR2:         rd_word = sh_cur2;
        REG_CUR3:         rd_word = sh_cur3;
        REG_ERROR_CODE:   rd_word = DW'(sh_error_code);
        REG_TRIGGER:      rd_word = DW'({pend_sp[m], pend_ctrl[m]});
        default:          rd_word = DW'(DEADBEEF);
      endcase
    end

    assign motor_rd[m]                      = rd_word;
    assign cfg_kp[m*DW +: DW]               = kp;
    assign cfg_ki[m*DW +: DW]               = ki;
    assign cfg_kd[m*DW +: DW]               = kd;
    assign cfg_pwm_limit[m*DW +: DW]        = pwm_limit;
    assign cfg_int_limit[m*DW +: DW]        = int_limit;
    assign cfg_deadband[m*DW +: DW]         = deadband;
    assign cfg_sp[m*DW +: DW]               = sp;
    assign cfg_control_mode[m*8 +: 8]       = control_mode;
  end

  // Global page write
  always_ff @(posedge clock) begin
    if (reset) begin
      status_freq <= 32'(STATUS_FREQ_RESET);
    end else if (write && page && reg_sel == GREG_STATUS_FREQ) begin
      status_freq <= 32'(writedata);
    end
  end

  // Trigger writes become one-cycle set pulses into the arbiter
  always_comb begin
    set_ctrl = '0;
    set_sp   = '0;
    if (write) begin
      if (page && reg_sel == GREG_BROADCAST) begin
        set_ctrl = {N{writedata[0]}};
        set_sp   = {N{writedata[1]}};
      end else if (!page && motor_ok && reg_sel == REG_TRIGGER) begin
        set_ctrl[motor_idx] = writedata[0];
        set_sp[motor_idx]   = writedata[1];
      end
    end
  end

  // Read mux across global page and in-range motor pages
  always_comb begin
    rd_value = DW'(DEADBEEF);
    if (page) begin
      case (reg_sel)
        GREG_STATUS_FREQ: rd_value = DW'(status_freq);
        GREG_PEND_CTRL:   rd_value = DW'(pend_ctrl);
        GREG_PEND_SP:     rd_value = DW'(pend_sp);
        GREG_NUM_MOTORS:  rd_value = DW'(NUMBER_OF_MOTORS);
        default:          rd_value = DW'(DEADBEEF);
      endcase
    end else if (motor_ok) begin
      rd_value = motor_rd[motor_idx];
    end
  end

  // Fixed latency-1 read: capture on the strobe edge, release waitrequest for one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_phase <= 1'b0;
      readdata <= '0;
    end else if (rd_phase) begin
      rd_phase <= 1'b0;
    end else if (read) begin
      rd_phase <= 1'b1;
      readdata <= rd_value;
    end
  end

  motor_update_arbiter #(
    .NUMBER_OF_MOTORS(N),
    .MI_W            (MI_W)
  ) u_arbiter (
    .clock    (clock),
    .reset    (reset),
    .set_ctrl (set_ctrl),
    .set_sp   (set_sp),
    .upd_ack  (upd_ack),
    .pend_ctrl(pend_ctrl),
    .pend_sp  (pend_sp),
    .upd_req  (upd_req),
    .upd_motor(upd_motor),
    .upd_kind (arb_kind)
  );

endmodule

// File: tb/tb_motor_ctrl_regfile.sv
// tb/tb_motor_ctrl_regfile.sv - scoreboard bench for the motor register file and update arbiter
module tb_motor_ctrl_regfile;

  localparam int N    = 6;
  localparam int DW   = 32;
  localparam int MI_W = 3;
  localparam int AW   = MI_W + 6;

  logic            clock = 1'b0;
  logic            reset;
  logic [AW-1:0]   address;
  logic            write, read;
  logic [DW-1:0]   writedata, readdata;
  logic            waitrequest;
  logic [N*DW-1:0] cfg_kp, cfg_ki, cfg_kd, cfg_pwm_limit, cfg_int_limit, cfg_deadband, cfg_sp;
  logic [N*8-1:0]  cfg_control_mode;
  logic [31:0]     status_update_frequency_Hz;
  logic [N*DW-1:0] st_enc0_pos, st_enc1_pos, st_enc0_vel, st_enc1_vel, st_cur1, st_cur2, st_cur3;
  logic [N*8-1:0]  st_error_code;
  logic            status_strobe;
  logic            upd_req;
  logic [MI_W-1:0] upd_motor;
  logic            upd_kind;
  logic            upd_ack;

  motor_ctrl_regfile dut (
    .clock(clock), .reset(reset), .address(address), .write(write), .read(read),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .cfg_kp(cfg_kp), .cfg_ki(cfg_ki), .cfg_kd(cfg_kd), .cfg_pwm_limit(cfg_pwm_limit),
    .cfg_int_limit(cfg_int_limit), .cfg_deadband(cfg_deadband), .cfg_sp(cfg_sp),
    .cfg_control_mode(cfg_control_mode), .status_update_frequency_Hz(status_update_frequency_Hz),
    .st_enc0_pos(st_enc0_pos), .st_enc1_pos(st_enc1_pos), .st_enc0_vel(st_enc0_vel),
    .st_enc1_vel(st_enc1_vel), .st_cur1(st_cur1), .st_cur2(st_cur2), .st_cur3(st_cur3),
    .st_error_code(st_error_code), .status_strobe(status_strobe),
    .upd_req(upd_req), .upd_motor(upd_motor), .upd_kind(upd_kind), .upd_ack(upd_ack)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0]   rd_q [$];
  logic [MI_W:0]   upd_q [$];
  logic            ack_en = 1'b0;
  int              dly = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] ma(input int m, input int r);
    return {1'b0, MI_W'(m), 5'(r)};
  endfunction

  function automatic logic [AW-1:0] ga(input int r);
    return {1'b1, MI_W'(0), 5'(r)};
  endfunction

  // Bus write: one cycle, zero wait states
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clock); #1;
    write = 1'b0;
  endtask

  // Bus read with optional same-edge strobe or write; expected value goes to the scoreboard
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                    input logic stb = 1'b0, input logic w = 1'b0, input logic [DW-1:0] wd = '0);
    int n;
    rd_q.push_back(exp);
    address = a; read = 1'b1; status_strobe = stb;
    if (w) begin write = 1'b1; writedata = wd; end
    @(negedge clock);
    chk("wait_hi", DW'(waitrequest), 1);
    @(posedge clock); #1;
    status_strobe = 1'b0; write = 1'b0;
    n = 0;
    while (waitrequest && n < 8) begin @(posedge clock); #1; n++; end
    chk("wait_len", DW'(n), 0);
    if (waitrequest && rd_q.size() != 0) void'(rd_q.pop_front());
    @(negedge clock);
    @(posedge clock); #1;
    read = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((upd_q.size() != 0 || upd_req) && n < budget) begin @(posedge clock); #1; n++; end
    chk("upd_drain", DW'(upd_q.size()), 0);
    chk("upd_idle", DW'(upd_req), 0);
  endtask

  // Read-data monitor
  always @(negedge clock) begin
    if (read && !waitrequest) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual=%h required=none", readdata);
      end else begin
        chk("readdata", readdata, rd_q.pop_front());
      end
    end
  end

  // Update-stream monitor: new request pops the scoreboard, held request must not change
  logic          prev_req = 1'b0;
  logic [MI_W:0] cur_upd  = '0;
  always @(negedge clock) begin
    if (upd_req && !prev_req) begin
      if (upd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL upd_unexpected actual=%h required=none", {upd_kind, upd_motor});
      end else begin
        cur_upd = upd_q.pop_front();
        chk("upd_req", DW'({upd_kind, upd_motor}), DW'(cur_upd));
      end
    end else if (upd_req) begin
      chk("upd_hold", DW'({upd_kind, upd_motor}), DW'(cur_upd));
    end
    prev_req = upd_req;
  end

  // Coms model: acknowledge each request after three cycles
  initial begin
    upd_ack = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (ack_en) begin
        if (upd_ack) begin
          upd_ack = 1'b0; dly = 0;
        end else if (upd_req) begin
          dly++;
          if (dly == 3) upd_ack = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    logic [DW-1:0] exp_kp [N];
    reset = 1'b1; address = '0; write = 1'b0; read = 1'b0; writedata = '0; status_strobe = 1'b0;
    st_enc0_pos = '0; st_enc1_pos = '0; st_enc0_vel = '0; st_enc1_vel = '0;
    st_cur1 = '0; st_cur2 = '0; st_cur3 = '0; st_error_code = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst_wait", DW'(waitrequest), 1);
    chk("rst_rdata", readdata, 0);
    chk("rst_req", DW'(upd_req), 0);
    chk("rst_pwm0", cfg_pwm_limit[0 +: DW], 127);
    chk("rst_ki0", cfg_ki[0 +: DW], 0);
    chk("rst_freq", status_update_frequency_Hz, 100);

    rd(ma(3, 'h00), 1);
    rd(ma(3, 'h03), 127);
    rd(ma(3, 'h04), 50);
    rd(ga('h00), 100);
    rd(ga('h03), 6);

    chk("kp5_before", cfg_kp[5*DW +: DW], 1);
    wr(ma(5, 'h00), 32'h12345678);
    chk("kp5_after", cfg_kp[5*DW +: DW], 32'h12345678);
    rd(ma(5, 'h00), 32'h12345678);
    rd(ma(4, 'h00), 1);

    rd(ma(1, 'h00), 1, 1'b0, 1'b1, 32'h55);
    rd(ma(1, 'h00), 32'h55);
    wr(ma(1, 'h06), 32'h1A5);
    rd(ma(1, 'h06), 32'hA5);

    st_enc0_pos[2*DW +: DW] = 7;
    rd(ma(2, 'h08), 0);
    st_enc0_pos[2*DW +: DW] = 9;
    st_error_code[2*8 +: 8] = 8'hE3;
    rd(ma(2, 'h08), 0, 1'b1);
    rd(ma(2, 'h08), 9);
    rd(ma(2, 'h0F), 32'hE3);

    rd(ma(7, 'h00), 32'hDEADBEEF);
    rd(ma(0, 'h1F), 32'hDEADBEEF);
    rd(ga('h05), 32'hDEADBEEF);
    wr(ma(7, 'h00), 32'hAAAA5555);
    wr(ma(0, 'h08), 32'hFFFF);
    wr(ga('h03), 32'h99);
    rd(ma(0, 'h08), 0);
    rd(ga('h03), 6);
    for (int m = 0; m < N; m++) exp_kp[m] = 1;
    exp_kp[1] = 32'h55;
    exp_kp[5] = 32'h12345678;
    for (int m = 0; m < N; m++) chk("kp_all", cfg_kp[m*DW +: DW], exp_kp[m]);

    ack_en = 1'b1;
    for (int m = 0; m < N; m++) upd_q.push_back({1'b1, MI_W'(m)});
    wr(ga('h04), 32'h2);
    wait_drain(300);
    rd(ga('h02), 0);

    ack_en = 1'b0;
    upd_q.push_back({1'b0, MI_W'(2)});
    upd_q.push_back({1'b0, MI_W'(3)});
    upd_q.push_back({1'b0, MI_W'(4)});
    upd_q.push_back({1'b0, MI_W'(2)});
    wr(ma(2, 'h10), 32'h1);
    wr(ma(3, 'h10), 32'h1);
    wr(ma(4, 'h10), 32'h1);
    n = 0;
    while (!upd_req && n < 50) begin @(posedge clock); #1; n++; end
    chk("req_seen", DW'(upd_req), 1);
    address = ma(2, 'h10); writedata = 32'h1; write = 1'b1; upd_ack = 1'b1;
    @(posedge clock); #1;
    write = 1'b0; upd_ack = 1'b0; ack_en = 1'b1;
    wait_drain(300);
    rd(ga('h01), 0);
    rd(ma(2, 'h10), 0);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
